// File: rtl/map_layer_engine_if.sv
// map_layer_engine_if: descriptor-write and collision-query bundle.
// master drives cfg_*/q_*; slave returns cfg_ready/q_ready and r_* results.
interface map_layer_engine_if #(
    parameter int NUM_RECT = 16,
    parameter int IDX_W    = 4
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [IDX_W-1:0]    cfg_idx;
    logic [9:0]          cfg_pivot_h;
    logic [9:0]          cfg_pivot_v;
    logic [9:0]          cfg_width;
    logic [9:0]          cfg_height;
    logic [9:0]          cfg_mem_h;
    logic [9:0]          cfg_mem_v;
    logic                cfg_visible;
    logic                cfg_solid;

    logic                q_valid;
    logic                q_ready;
    logic [9:0]          q_h;
    logic [9:0]          q_v;
    logic [9:0]          q_w;
    logic [9:0]          q_hh;

    logic                r_valid;
    logic                r_hit;
    logic [IDX_W-1:0]    r_idx;
    logic [NUM_RECT-1:0] r_mask;

    modport master (
        output cfg_valid, cfg_idx, cfg_pivot_h, cfg_pivot_v,
        output cfg_width, cfg_height, cfg_mem_h, cfg_mem_v,
        output cfg_visible, cfg_solid,
        output q_valid, q_h, q_v, q_w, q_hh,
        input  cfg_ready, q_ready,
        input  r_valid, r_hit, r_idx, r_mask
    );

    modport slave (
        input  cfg_valid, cfg_idx, cfg_pivot_h, cfg_pivot_v,
        input  cfg_width, cfg_height, cfg_mem_h, cfg_mem_v,
        input  cfg_visible, cfg_solid,
        input  q_valid, q_h, q_v, q_w, q_hh,
        output cfg_ready, q_ready,
        output r_valid, r_hit, r_idx, r_mask
    );
endinterface

// File: rtl/map_layer_engine.sv
// map_layer_engine: runtime-loaded rectangle renderer plus collision scanner.
// Ports: clk, rst (async low), en, vga_h/v, vis_set/clr, addr, hit, hit_idx,
// bus (slave): cfg write handshake, collision query and result strobe.
module map_layer_engine #(
    parameter int NUM_RECT    = 16,
    parameter int IDX_W       = 4,
    parameter int ADDR_W      = 17,
    parameter int MEM_STRIDE  = 320,
    parameter int BG_ADDR     = 12900,
    parameter int SCALE_SHIFT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [9:0]          vga_h,
    input  logic [9:0]          vga_v,
    input  logic [NUM_RECT-1:0] vis_set,
    input  logic [NUM_RECT-1:0] vis_clr,
    output logic [ADDR_W-1:0]   addr,
    output logic                hit,
    output logic [IDX_W-1:0]    hit_idx,
    map_layer_engine_if.slave   bus
);
    localparam int SW = (NUM_RECT > 1) ? $clog2(NUM_RECT) : 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_RECT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    // slot descriptors
    logic [9:0]          ph_q [NUM_RECT];
    logic [9:0]          pv_q [NUM_RECT];
    logic [9:0]          w_q  [NUM_RECT];
    logic [9:0]          ht_q [NUM_RECT];
    logic [9:0]          mh_q [NUM_RECT];
    logic [9:0]          mv_q [NUM_RECT];
    logic [NUM_RECT-1:0] vis_q;
    logic [NUM_RECT-1:0] solid_q;

    logic ready_q;
    logic cfg_we;

    assign bus.cfg_ready = ready_q;
    assign bus.q_ready   = ready_q;
    assign cfg_we        = bus.cfg_valid && ready_q;

    // A descriptor write to slot i overrides that slot's visibility pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_RECT; i++) begin
                ph_q[i] <= '0;
                pv_q[i] <= '0;
                w_q[i]  <= '0;
                ht_q[i] <= '0;
                mh_q[i] <= '0;
                mv_q[i] <= '0;
            end
            vis_q   <= '0;
            solid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_RECT; i++) begin
                if (cfg_we && bus.cfg_idx == IDX_W'(i)) begin
                    ph_q[i]    <= bus.cfg_pivot_h;
                    pv_q[i]    <= bus.cfg_pivot_v;
                    w_q[i]     <= bus.cfg_width;
                    ht_q[i]    <= bus.cfg_height;
                    mh_q[i]    <= bus.cfg_mem_h;
                    mv_q[i]    <= bus.cfg_mem_v;
                    vis_q[i]   <= bus.cfg_visible;
                    solid_q[i] <= bus.cfg_solid;
                end else begin
                    vis_q[i] <= (vis_q[i] | vis_set[i]) & ~vis_clr[i];
                end
            end
        end
    end

    // ---------------- render stage 1: per-slot hit test ----------------
    logic [9:0]          lh;
    logic [9:0]          lv;
    logic [NUM_RECT-1:0] cov_d;
    logic [NUM_RECT-1:0] hv_q;
    logic [9:0]          dh_q [NUM_RECT];
    logic [9:0]          dv_q [NUM_RECT];

    assign lh = vga_h >> SCALE_SHIFT;
    assign lv = vga_v >> SCALE_SHIFT;

    // 11-bit bounds so pivot+size never wraps; size 0 gives an empty range.
    always_comb begin
        for (int i = 0; i < NUM_RECT; i++) begin
            cov_d[i] = vis_q[i]
                && ({1'b0, lh} >= {1'b0, ph_q[i]})
                && ({1'b0, lh} < {1'b0, ph_q[i]} + {1'b0, w_q[i]})
                && ({1'b0, lv} >= {1'b0, pv_q[i]})
                && ({1'b0, lv} < {1'b0, pv_q[i]} + {1'b0, ht_q[i]});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hv_q <= '0;
            for (int i = 0; i < NUM_RECT; i++) begin
                dh_q[i] <= '0;
                dv_q[i] <= '0;
            end
        end else begin
            hv_q <= cov_d;
            for (int i = 0; i < NUM_RECT; i++) begin
                dh_q[i] <= lh - ph_q[i];
                dv_q[i] <= lv - pv_q[i];
            end
        end
    end

    // ---------------- render stage 2: priority + address ----------------
    logic              win_found;
    logic [SW-1:0]     win;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_q;
    logic              hit_q;
    logic [IDX_W-1:0]  hit_idx_q;

    // Scan high to low so the lowest set index is the one left standing.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        for (int i = NUM_RECT - 1; i >= 0; i--) begin
            if (hv_q[i]) begin
                win_found = 1'b1;
                win       = SW'(i);
            end
        end
        row    = ADDR_W'(mv_q[win]) + ADDR_W'(dv_q[win]);
        addr_d = row * ADDR_W'(MEM_STRIDE)
               + ADDR_W'(mh_q[win]) + ADDR_W'(dh_q[win]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= ADDR_W'(BG_ADDR);
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
        end else if (en && win_found) begin
            addr_q    <= addr_d;
            hit_q     <= 1'b1;
            hit_idx_q <= IDX_W'(win);
        end else begin
            addr_q    <= ADDR_W'(BG_ADDR);
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
        end
    end

    assign addr    = addr_q;
    assign hit     = hit_q;
    assign hit_idx = hit_idx_q;

    // ---------------- collision query engine ----------------
    state_e              state_q;
    logic [SW-1:0]       sidx_q;
    logic [9:0]          bh_q;
    logic [9:0]          bv_q;
    logic [9:0]          bw_q;
    logic [9:0]          bhh_q;
    logic                r_valid_q;
    logic                r_hit_q;
    logic [IDX_W-1:0]    r_idx_q;
    logic [NUM_RECT-1:0] r_mask_q;

    logic [10:0] s_l, s_r, s_t, s_b;
    logic [10:0] b_l, b_r, b_t, b_b;
    logic        ov;

    // Strict inequalities: boxes that only share an edge do not collide.
    always_comb begin
        s_l = {1'b0, ph_q[sidx_q]};
        s_t = {1'b0, pv_q[sidx_q]};
        s_r = s_l + {1'b0, w_q[sidx_q]};
        s_b = s_t + {1'b0, ht_q[sidx_q]};
        b_l = {1'b0, bh_q};
        b_t = {1'b0, bv_q};
        b_r = b_l + {1'b0, bw_q};
        b_b = b_t + {1'b0, bhh_q};
        ov  = solid_q[sidx_q]
            && (b_l < s_r) && (s_l < b_r)
            && (b_t < s_b) && (s_t < b_b);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            sidx_q    <= '0;
            bh_q      <= '0;
            bv_q      <= '0;
            bw_q      <= '0;
            bhh_q     <= '0;
            r_valid_q <= 1'b0;
            r_hit_q   <= 1'b0;
            r_idx_q   <= '0;
            r_mask_q  <= '0;
        end else begin
            r_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.q_valid) begin
                        bh_q     <= bus.q_h;
                        bv_q     <= bus.q_v;
                        bw_q     <= bus.q_w;
                        bhh_q    <= bus.q_hh;
                        r_hit_q  <= 1'b0;
                        r_idx_q  <= '0;
                        r_mask_q <= '0;
                        sidx_q   <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    if (ov) begin
                        r_mask_q[sidx_q] <= 1'b1;
                        // empty mask means this is the first overlap
                        if (r_mask_q == '0) begin
                            r_idx_q <= IDX_W'(sidx_q);
                        end
                    end
                    if (sidx_q == LAST) begin
                        state_q <= DONE;
                    end else begin
                        sidx_q <= sidx_q + 1'b1;
                    end
                end
                DONE: begin
                    r_valid_q <= 1'b1;
                    r_hit_q   <= |r_mask_q;
                    ready_q   <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.r_valid = r_valid_q;
    assign bus.r_hit   = r_hit_q;
    assign bus.r_idx   = r_idx_q;
    assign bus.r_mask  = r_mask_q;
endmodule

// File: tb/tb_map_layer_engine.sv
// tb_map_layer_engine: directed scoreboard bench for map_layer_engine.
// Expected pixel/query results come from a behavioural slot-table model.
module tb_map_layer_engine;
    localparam int NR = 16;
    localparam int IW = 5;
    localparam int AW = 17;
    localparam int BG = 12900;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [9:0]    vga_h;
    logic [9:0]    vga_v;
    logic [NR-1:0] vis_set;
    logic [NR-1:0] vis_clr;
    logic [AW-1:0] addr;
    logic          hit;
    logic [IW-1:0] hit_idx;

    map_layer_engine_if #(.NUM_RECT(NR), .IDX_W(IW)) bus ();

    map_layer_engine #(.NUM_RECT(NR), .IDX_W(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .vga_h   (vga_h),
        .vga_v   (vga_v),
        .vis_set (vis_set),
        .vis_clr (vis_clr),
        .addr    (addr),
        .hit     (hit),
        .hit_idx (hit_idx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          h;
        logic [IW-1:0] i;
    } pix_t;

    typedef struct packed {
        logic          h;
        logic [IW-1:0] i;
        logic [NR-1:0] m;
    } res_t;

    pix_t pq[$];
    res_t rq[$];

    int m_ph[NR], m_pv[NR], m_w[NR], m_ht[NR], m_mh[NR], m_mv[NR];
    bit m_vis[NR], m_sol[NR];

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) begin
            m_ph[i] = 0; m_pv[i] = 0; m_w[i] = 0; m_ht[i] = 0;
            m_mh[i] = 0; m_mv[i] = 0; m_vis[i] = 0; m_sol[i] = 0;
        end
    endfunction

    function automatic pix_t pmodel(input int h, input int v, input bit e);
        pix_t r;
        r.a = AW'(BG);
        r.h = 1'b0;
        r.i = '0;
        if (e) begin
            for (int i = NR - 1; i >= 0; i--) begin
                if (m_vis[i] && h >= m_ph[i] && h < m_ph[i] + m_w[i]
                    && v >= m_pv[i] && v < m_pv[i] + m_ht[i]) begin
                    r.a = AW'((m_mv[i] + v - m_pv[i]) * 320
                              + m_mh[i] + h - m_ph[i]);
                    r.h = 1'b1;
                    r.i = IW'(i);
                end
            end
        end
        return r;
    endfunction

    function automatic res_t qmodel(input int h, input int v,
                                    input int w, input int hh);
        res_t r;
        r = '0;
        for (int i = NR - 1; i >= 0; i--) begin
            if (m_sol[i] && h < m_ph[i] + m_w[i] && m_ph[i] < h + w
                && v < m_pv[i] + m_ht[i] && m_pv[i] < v + hh) begin
                r.m[i] = 1'b1;
                r.i    = IW'(i);
                r.h    = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic wr(input int idx, input int ph, input int pv,
                      input int w, input int ht, input int mh,
                      input int mv, input bit vis, input bit sol);
        @(negedge clk);
        bus.cfg_idx     = IW'(idx);
        bus.cfg_pivot_h = 10'(ph);
        bus.cfg_pivot_v = 10'(pv);
        bus.cfg_width   = 10'(w);
        bus.cfg_height  = 10'(ht);
        bus.cfg_mem_h   = 10'(mh);
        bus.cfg_mem_v   = 10'(mv);
        bus.cfg_visible = vis;
        bus.cfg_solid   = sol;
        bus.cfg_valid   = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        if (idx < NR) begin
            m_ph[idx] = ph; m_pv[idx] = pv; m_w[idx] = w; m_ht[idx] = ht;
            m_mh[idx] = mh; m_mv[idx] = mv;
            m_vis[idx] = vis; m_sol[idx] = sol;
        end
    endtask

    task automatic vpulse(input logic [NR-1:0] s, input logic [NR-1:0] c);
        @(negedge clk);
        vis_set = s;
        vis_clr = c;
        for (int i = 0; i < NR; i++) begin
            if (c[i]) m_vis[i] = 1'b0;
            else if (s[i]) m_vis[i] = 1'b1;
        end
        step();
        vis_set = '0;
        vis_clr = '0;
    endtask

    task automatic px(input string tag, input int h, input int v);
        pix_t e;
        @(negedge clk);
        vga_h = 10'(h * 2);
        vga_v = 10'(v * 2);
        pq.push_back(pmodel(h, v, en));
        step();
        step();
        e = pq.pop_front();
        chk({tag, "_addr"}, 32'(addr), 32'(e.a));
        chk({tag, "_hit"}, 32'(hit), 32'(e.h));
        chk({tag, "_idx"}, 32'(hit_idx), 32'(e.i));
    endtask

    task automatic result_check(input string tag);
        res_t e;
        e = rq.pop_front();
        chk({tag, "_r_hit"}, 32'(bus.r_hit), 32'(e.h));
        chk({tag, "_r_idx"}, 32'(bus.r_idx), 32'(e.i));
        chk({tag, "_r_mask"}, 32'(bus.r_mask), 32'(e.m));
    endtask

    task automatic query(input string tag, input int h, input int v,
                         input int w, input int hh);
        int n;
        bit seen;
        @(negedge clk);
        bus.q_h = 10'(h);
        bus.q_v = 10'(v);
        bus.q_w = 10'(w);
        bus.q_hh = 10'(hh);
        bus.q_valid = 1'b1;
        rq.push_back(qmodel(h, v, w, hh));
        step();
        n = 1;
        bus.q_valid = 1'b0;
        chk({tag, "_q_ready_busy"}, 32'(bus.q_ready), 32'd0);
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (bus.r_valid === 1'b1) seen = 1'b1;
            else begin
                step();
                n++;
            end
        end
        chk({tag, "_r_valid_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'd18);
        result_check(tag);
        step();
        chk({tag, "_r_valid_one_cycle"}, 32'(bus.r_valid), 32'd0);
        chk({tag, "_r_mask_hold"}, 32'(bus.r_mask), 32'(qmodel(h, v, w, hh).m));
    endtask

    initial begin
        int n;
        bit seen;
        pix_t e;
        model_clear();
        rst = 1'b0;
        en = 1'b1;
        vga_h = '0;
        vga_v = '0;
        vis_set = '0;
        vis_clr = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_pivot_h = '0;
        bus.cfg_pivot_v = '0;
        bus.cfg_width = '0;
        bus.cfg_height = '0;
        bus.cfg_mem_h = '0;
        bus.cfg_mem_v = '0;
        bus.cfg_visible = 1'b0;
        bus.cfg_solid = 1'b0;
        bus.q_valid = 1'b0;
        bus.q_h = '0;
        bus.q_v = '0;
        bus.q_w = '0;
        bus.q_hh = '0;
        step();
        step();

        chk("rst_addr", 32'(addr), BG);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_hit_idx", 32'(hit_idx), 32'd0);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("rst_q_ready", 32'(bus.q_ready), 32'd1);
        chk("rst_r_valid", 32'(bus.r_valid), 32'd0);
        chk("rst_r_mask", 32'(bus.r_mask), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // single slot, first pixel
        wr(0, 10, 182, 230, 8, 50, 215, 1'b1, 1'b0);
        px("t1", 20, 184);
        chk("t1_addr_const", 32'(addr), 32'd69500);

        // overlap priority and visibility pulses
        wr(1, 15, 180, 20, 10, 0, 0, 1'b1, 1'b0);
        px("t2_both", 20, 184);
        vpulse('0, NR'(1));
        px("t2_clr0", 20, 184);
        chk("t2_slot1_addr_const", 32'(addr), 32'd1285);
        vpulse(NR'(1), NR'(1));
        px("t2_setclr0", 20, 184);
        vpulse(NR'(1), '0);
        px("t2_set0", 20, 184);

        // misses, right edge, render disable
        px("t3_out", 300, 10);
        px("t3_edge_in", 239, 184);
        px("t3_edge_out", 240, 184);
        en = 1'b0;
        px("t3_en0", 20, 184);
        en = 1'b1;

        // out-of-range slot index is dropped
        wr(16, 0, 0, 600, 400, 7, 7, 1'b1, 1'b1);
        px("t5_idx16_in", 20, 184);
        px("t5_idx16_out", 300, 10);

        // collision queries
        wr(3, 105, 105, 10, 10, 0, 0, 1'b0, 1'b1);
        wr(7, 95, 95, 10, 10, 0, 0, 1'b0, 1'b1);
        wr(5, 200, 200, 5, 5, 0, 0, 1'b0, 1'b1);
        query("t4_overlap", 100, 100, 10, 10);
        query("t4_touch", 115, 100, 10, 10);

        // cfg write stalls during a scan
        @(negedge clk);
        bus.q_h = 10'd100;
        bus.q_v = 10'd100;
        bus.q_w = 10'd10;
        bus.q_hh = 10'd10;
        bus.q_valid = 1'b1;
        rq.push_back(qmodel(100, 100, 10, 10));
        step();
        bus.q_valid = 1'b0;
        bus.cfg_idx = IW'(9);
        bus.cfg_pivot_h = 10'd0;
        bus.cfg_pivot_v = 10'd0;
        bus.cfg_width = 10'd5;
        bus.cfg_height = 10'd5;
        bus.cfg_mem_h = 10'd1;
        bus.cfg_mem_v = 10'd1;
        bus.cfg_visible = 1'b1;
        bus.cfg_solid = 1'b0;
        bus.cfg_valid = 1'b1;
        vga_h = 10'd4;
        vga_v = 10'd4;
        step();
        step();
        chk("t5_cfg_ready_busy", 32'(bus.cfg_ready), 32'd0);
        chk("t5_no_early_write", 32'(hit), 32'd0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (bus.r_valid === 1'b1) seen = 1'b1;
            else begin
                step();
                n++;
            end
        end
        chk("t5_r_valid_seen", 32'(seen), 32'd1);
        result_check("t5");
        chk("t5_cfg_ready_after", 32'(bus.cfg_ready), 32'd1);
        step();
        bus.cfg_valid = 1'b0;
        m_ph[9] = 0; m_pv[9] = 0; m_w[9] = 5; m_ht[9] = 5;
        m_mh[9] = 1; m_mv[9] = 1; m_vis[9] = 1; m_sol[9] = 0;
        pq.push_back(pmodel(2, 2, en));
        step();
        step();
        e = pq.pop_front();
        chk("t5_late_write_addr", 32'(addr), 32'(e.a));
        chk("t5_late_write_idx", 32'(hit_idx), 32'(e.i));

        // reset in the middle of a scan
        @(negedge clk);
        bus.q_valid = 1'b1;
        step();
        bus.q_valid = 1'b0;
        step();
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_clear();
        chk("t6_q_ready", 32'(bus.q_ready), 32'd1);
        chk("t6_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("t6_r_valid", 32'(bus.r_valid), 32'd0);
        chk("t6_r_hit", 32'(bus.r_hit), 32'd0);
        chk("t6_r_idx", 32'(bus.r_idx), 32'd0);
        chk("t6_r_mask", 32'(bus.r_mask), 32'd0);
        chk("t6_addr", 32'(addr), BG);
        chk("t6_hit", 32'(hit), 32'd0);
        chk("t6_hit_idx", 32'(hit_idx), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (bus.r_valid === 1'b1) seen = 1'b1;
        end
        chk("t6_no_r_valid", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
